// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU load/store port, the host loader port and the
// single-ported data memory.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          host_req, host_we, host_lock, host_ack;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_lock, host_addr, host_wdata,
    input  mem_rdata,
    output cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata,
    output mem_we, mem_addr, mem_wdata, busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_lock, host_addr, host_wdata,
    output mem_rdata,
    input  cpu_ack, cpu_rdata, cpu_stall, host_ack, host_rdata,
    input  mem_we, mem_addr, mem_wdata, busy, owner
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU and a host port,
// with a bounded host burst lock. Each access is IDLE/ACK -> XFER -> ACK.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  localparam logic [3:0] MAXB = 4'(MAX_BURST);

  state_t        state, state_nxt;
  logic          owner_q, last_owner, lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata, cpu_rdata_q, host_rdata_q;
  logic [3:0]    burst_cnt;
  logic          cpu_ok, host_ok, lock, gnt_cpu, gnt_host;

  // A side is eligible in IDLE, or in ACK when the other side is being acked.
  // While the lock holds, the CPU is not granted even in the host's ACK cycle,
  // so the host wins again from IDLE.
  always_comb begin
    cpu_ok   = bus.cpu_req  & ((state == IDLE) | ((state == ACK) &  owner_q));
    host_ok  = bus.host_req & ((state == IDLE) | ((state == ACK) & ~owner_q));
    lock     = bus.host_lock & bus.host_req & (burst_cnt < MAXB);
    gnt_host = host_ok & (~cpu_ok | lock | ~last_owner);
    gnt_cpu  = cpu_ok & ~gnt_host & ~lock;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_cpu | gnt_host) state_nxt = XFER;
      XFER:    state_nxt = ACK;
      ACK:     state_nxt = (gnt_cpu | gnt_host) ? XFER : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q      <= 1'b0;
      last_owner   <= 1'b1;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
      burst_cnt    <= '0;
    end else begin
      if (gnt_cpu | gnt_host) begin
        owner_q    <= gnt_host;
        last_owner <= gnt_host;
        lat_we     <= gnt_host ? bus.host_we    : bus.cpu_we;
        lat_addr   <= gnt_host ? bus.host_addr  : bus.cpu_addr;
        lat_wdata  <= gnt_host ? bus.host_wdata : bus.cpu_wdata;
        if (gnt_host && bus.host_lock)
          burst_cnt <= (burst_cnt < MAXB) ? burst_cnt + 4'd1 : burst_cnt;
        else
          burst_cnt <= '0;
      end
      if (state == XFER && !lat_we) begin
        if (owner_q) host_rdata_q <= bus.mem_rdata;
        else         cpu_rdata_q  <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_we     = (state == XFER) & lat_we;
  assign bus.mem_addr   = lat_addr;
  assign bus.mem_wdata  = lat_wdata;
  assign bus.cpu_ack    = (state == ACK) & ~owner_q;
  assign bus.host_ack   = (state == ACK) &  owner_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_ack;
  assign bus.busy       = (state != IDLE);
  assign bus.owner      = owner_q;
endmodule
